// File: rtl/tmds_serializer_nch.sv
// NUM_CH-lane WIDTH:1 TMDS serializer with a one-deep holding buffer, idle-word fill and sticky underflow.
// Define TMDS_SERIALIZER_CLK_CH_EN to add the o_clk_serial clock-pattern lane.
module tmds_serializer_nch #(
  parameter int          NUM_CH    = 3,
  parameter int          WIDTH     = 10,
  parameter int          MSB_FIRST = 0,
  parameter logic [63:0] IDLE_WORD = 64'b1101010100
) (
  input  logic                      i_tmdsclk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [NUM_CH*WIDTH-1:0]   i_data,
  output logic [NUM_CH-1:0]         o_serial,
  output logic                      o_word_strobe,
  output logic                      o_underflow,
  input  logic                      i_clr_underflow
`ifdef TMDS_SERIALIZER_CLK_CH_EN
  ,
  output logic                      o_clk_serial
`endif
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] IDLE_W  = WIDTH'(IDLE_WORD);

  logic [CW-1:0]            bit_cnt;
  logic                     hold_full;
  logic [NUM_CH*WIDTH-1:0]  hold;
  logic [WIDTH-1:0]         shifter [NUM_CH];
  logic                     underflow;
  logic                     load_now;
  logic                     xfer;
  logic                     starve;

  assign load_now      = (bit_cnt == LAST_BIT);
  assign o_ready       = i_reset & (~hold_full | load_now);
  assign xfer          = i_valid & o_ready;
  assign starve        = load_now & ~hold_full & ~xfer;
  assign o_word_strobe = load_now;
  assign o_underflow   = underflow;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0)
      return {w[WIDTH-2:0], 1'b0};
    else
      return {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge i_tmdsclk) begin
    if (!i_reset) begin
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      hold      <= '0;
    end else begin
      bit_cnt <= load_now ? '0 : bit_cnt + CW'(1);
      if (load_now) begin
        // An empty hold on the load edge means a transfer bypasses straight into the shifters.
        if (hold_full) begin
          if (xfer)
            hold <= i_data;
          else
            hold_full <= 1'b0;
        end
      end else if (xfer) begin
        hold      <= i_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_tmdsclk) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_CH; k++)
        shifter[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load_now) begin
          if (hold_full)
            shifter[k] <= hold[k*WIDTH +: WIDTH];
          else if (xfer)
            shifter[k] <= i_data[k*WIDTH +: WIDTH];
          else
            shifter[k] <= IDLE_W;
        end else begin
          shifter[k] <= shift_one(shifter[k]);
        end
      end
    end
  end

  // A starved load sets the flag even when a clear arrives on the same edge.
  always_ff @(posedge i_tmdsclk) begin
    if (!i_reset)
      underflow <= 1'b0;
    else if (starve)
      underflow <= 1'b1;
    else if (i_clr_underflow)
      underflow <= 1'b0;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign o_serial[k] = (MSB_FIRST != 0) ? shifter[k][WIDTH-1] : shifter[k][0];
  end

`ifdef TMDS_SERIALIZER_CLK_CH_EN
  // The clock lane always emits WIDTH/2 ones first, so the ones sit at the end shifted out first.
  localparam logic [WIDTH-1:0] HALF_ONES = WIDTH'({(WIDTH/2){1'b1}});
  localparam logic [WIDTH-1:0] CLK_WORD  = (MSB_FIRST != 0) ? ~HALF_ONES : HALF_ONES;

  logic [WIDTH-1:0] clk_shifter;

  always_ff @(posedge i_tmdsclk) begin
    if (!i_reset)
      clk_shifter <= '0;
    else if (load_now)
      clk_shifter <= CLK_WORD;
    else
      clk_shifter <= shift_one(clk_shifter);
  end

  assign o_clk_serial = (MSB_FIRST != 0) ? clk_shifter[WIDTH-1] : clk_shifter[0];
`endif

endmodule

// File: tb/tb_tmds_serializer_nch.sv
// Directed bench for tmds_serializer_nch: a default 3x10 LSB-first instance and a 4x8 MSB-first instance.
// Clock-lane checks are compiled in when TMDS_SERIALIZER_CLK_CH_EN is defined.
module tb_tmds_serializer_nch;

  localparam logic [9:0] IDLE = 10'b1101010100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        valid;
  logic        clr;
  logic [29:0] data;
  logic        ready;
  logic        strobe;
  logic        underflow;
  logic [2:0]  serial;

  logic        reset2_n;
  logic        valid2;
  logic [31:0] data2;
  logic        ready2;
  logic        strobe2;
  logic        underflow2;
  logic [3:0]  serial2;

`ifdef TMDS_SERIALIZER_CLK_CH_EN
  logic        clk_serial1;
  logic        clk_serial2;
`endif

  int tests = 0;
  int fails = 0;

  tmds_serializer_nch #(.NUM_CH(3), .WIDTH(10), .MSB_FIRST(0)) dut (
    .i_tmdsclk       (clk),
    .i_reset         (reset_n),
    .i_valid         (valid),
    .o_ready         (ready),
    .i_data          (data),
    .o_serial        (serial),
    .o_word_strobe   (strobe),
    .o_underflow     (underflow),
    .i_clr_underflow (clr)
`ifdef TMDS_SERIALIZER_CLK_CH_EN
    ,
    .o_clk_serial    (clk_serial1)
`endif
  );

  tmds_serializer_nch #(.NUM_CH(4), .WIDTH(8), .MSB_FIRST(1)) dut2 (
    .i_tmdsclk       (clk),
    .i_reset         (reset2_n),
    .i_valid         (valid2),
    .o_ready         (ready2),
    .i_data          (data2),
    .o_serial        (serial2),
    .o_word_strobe   (strobe2),
    .o_underflow     (underflow2),
    .i_clr_underflow (1'b0)
`ifdef TMDS_SERIALIZER_CLK_CH_EN
    ,
    .o_clk_serial    (clk_serial2)
`endif
  );

  typedef struct {
    logic        valid;
    logic        clr;
    logic [29:0] data;
    logic [29:0] exp_bits;
    logic        exp_uf;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [29:0] d, input logic c);
    valid = v;
    data  = d;
    clr   = c;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Call right after a load edge; bit i of lane k lands in got[k*10+i], ending on the next strobe.
  task automatic captureWord(output logic [29:0] got);
    got = '0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) tick();
      for (int k = 0; k < 3; k++) got[k*10 + i] = serial[k];
    end
  endtask

  task automatic waitStrobe(input int max_cycles);
    int n;
    n = 0;
    while (strobe !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("strobe_wait", strobe, 1);
  endtask

  function automatic logic [29:0] pat(input int n);
    logic [29:0] r;
    for (int k = 0; k < 3; k++) r[k*10 +: 10] = 10'(n*37 + k*101 + 5);
    return r;
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [29:0] got;
    logic [31:0] got2;
    logic [7:0]  clk_got;
    logic        rdy_now;
    int          sent;
    int          rdy_err;
    int          n;

    vecs[0] = '{1'b1, 1'b0, {10'h155, 10'h000, 10'h3FF}, {10'h155, 10'h000, 10'h3FF}, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 30'h2AAA_AAAA, {IDLE, IDLE, IDLE}, 1'b1};
    vecs[2] = '{1'b1, 1'b1, {10'h001, 10'h0F0, 10'h2AA}, {10'h001, 10'h0F0, 10'h2AA}, 1'b0};
    vecs[3] = '{1'b1, 1'b0, {10'h200, 10'h3C3, 10'h123}, {10'h200, 10'h3C3, 10'h123}, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 30'h1555_5555, {IDLE, IDLE, IDLE}, 1'b1};
    vecs[5] = '{1'b1, 1'b1, {10'h3FF, 10'h1FE, 10'h0AB}, {10'h3FF, 10'h1FE, 10'h0AB}, 1'b0};

    applyStimulus(1'b0, '0, 1'b0);
    reset_n  = 1'b0;
    reset2_n = 1'b0;
    valid2   = 1'b0;
    data2    = '0;

    repeat (5) tick();
    checkOutput("reset_serial", serial, 0);
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_strobe", strobe, 0);
    checkOutput("reset_underflow", underflow, 0);

    reset_n = 1'b1;
    repeat (8) tick();
    checkOutput("strobe_low_before_first_load", strobe, 0);
    tick();
    checkOutput("first_strobe_cycle9", strobe, 1);
    checkOutput("ready_at_first_load", ready, 1);
    tick();
    captureWord(got);
    checkOutput("idle_word_lanes", got, {IDLE, IDLE, IDLE});
    checkOutput("underflow_after_idle", underflow, 1);

    // Each vector is offered on the load edge with the hold empty (bypass or idle fill).
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].clr);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput($sformatf("vec%0d_underflow", i), underflow, vecs[i].exp_uf);
      captureWord(got);
      checkOutput($sformatf("vec%0d_lanes", i), got, vecs[i].exp_bits);
      checkOutput($sformatf("vec%0d_strobe_end", i), strobe, 1);
    end

    sent    = 0;
    rdy_err = 0;
    got     = '0;
    for (int c = 0; c < 500; c++) begin
      applyStimulus(sent < 50, pat(sent), 1'b0);
      rdy_now = ready;
      if (c >= 2 && c <= 490 && rdy_now !== (c % 10 == 0)) rdy_err++;
      tick();
      if (rdy_now && valid) sent++;
      for (int k = 0; k < 3; k++) got[k*10 + (c % 10)] = serial[k];
      if (c % 10 == 9) checkOutput($sformatf("stream_word%0d", c / 10), got, pat(c / 10));
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("stream_words_sent", sent, 50);
    checkOutput("stream_ready_errors", rdy_err, 0);
    checkOutput("stream_no_underflow", underflow, 0);

    // Word B goes through the hold; word C arrives on the load edge while the hold is still full.
    applyStimulus(1'b1, pat(100), 1'b0);
    tick();
    checkOutput("ready_after_bypass", ready, 1);
    applyStimulus(1'b1, pat(101), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("ready_low_hold_full", ready, 0);
    waitStrobe(20);
    checkOutput("ready_on_load_hold_full", ready, 1);
    applyStimulus(1'b1, pat(102), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("ready_low_hold_refilled", ready, 0);
    captureWord(got);
    checkOutput("hold_word_b", got, pat(101));
    tick();
    captureWord(got);
    checkOutput("hold_word_c", got, pat(102));
    checkOutput("hold_path_no_underflow", underflow, 0);

    tick();
    repeat (2) tick();
    checkOutput("idle_bit2_before_reset", serial, 3'b111);
    checkOutput("underflow_before_reset", underflow, 1);
    reset_n = 1'b0;
    tick();
    checkOutput("midword_reset_serial", serial, 0);
    checkOutput("midword_reset_ready", ready, 0);
    checkOutput("midword_reset_strobe", strobe, 0);
    checkOutput("midword_reset_underflow", underflow, 0);
    reset_n = 1'b1;

    reset2_n = 1'b1;
    n = 0;
    while (strobe2 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("dut2_first_load_delay", n, 7);
    valid2 = 1'b1;
    data2  = {8'hC8, 8'h80, 8'h01, 8'hA5};
    tick();
    valid2  = 1'b0;
    got2    = '0;
    clk_got = '0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      for (int k = 0; k < 4; k++) got2[k*8 + i] = serial2[k];
`ifdef TMDS_SERIALIZER_CLK_CH_EN
      clk_got[i] = clk_serial2;
`endif
    end
    checkOutput("dut2_msb_first_lanes", got2, {8'h13, 8'h01, 8'h80, 8'hA5});
    checkOutput("dut2_no_underflow", underflow2, 0);
`ifdef TMDS_SERIALIZER_CLK_CH_EN
    checkOutput("dut2_clk_lane", clk_got, 8'h0F);
`endif

    tick();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      for (int k = 0; k < 4; k++) got2[k*8 + i] = serial2[k];
`ifdef TMDS_SERIALIZER_CLK_CH_EN
      clk_got[i] = clk_serial2;
`endif
    end
    checkOutput("dut2_idle_truncated", got2, {4{8'h2A}});
    checkOutput("dut2_underflow", underflow2, 1);
`ifdef TMDS_SERIALIZER_CLK_CH_EN
    checkOutput("dut2_clk_lane_on_underflow", clk_got, 8'h0F);
`endif

    tick();
    tick();
    checkOutput("dut2_idle_bit1", serial2, 4'hF);
`ifdef TMDS_SERIALIZER_CLK_CH_EN
    checkOutput("dut2_clk_bit1", clk_serial2, 1);
`endif
    reset2_n = 1'b0;
    tick();
    checkOutput("dut2_reset_serial", serial2, 0);
    checkOutput("dut2_reset_ready", ready2, 0);
    checkOutput("dut2_reset_strobe", strobe2, 0);
    checkOutput("dut2_reset_underflow", underflow2, 0);
`ifdef TMDS_SERIALIZER_CLK_CH_EN
    checkOutput("dut2_reset_clk_lane", clk_serial2, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
